chacha_qr_host: RTL and testbench



---
 rtl/chacha_qr_pkg.sv | 42 ++++
 rtl/chacha_qr_host_if.sv | 39 +++
 rtl/chacha_qr_host.sv | 134 +++++++++++++
 tb/tb_chacha_qr_host.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chacha_qr_pkg.sv
// Shared types and constants for the ChaCha quarter-round host.
// Holds the FSM state encoding, the peripheral address field layout
// and the word/byte geometry of the 128-bit {d,c,b,a} state.
package chacha_qr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROUND,
    ST_READ,
    ST_DONE
  } qr_state_e;

  // Peripheral byte address: [3:2] selects the word, [1:0] the byte lane.
  localparam int QR_ADDR_W    = 4;
  localparam int WORD_SEL_MSB = 3;
  localparam int WORD_SEL_LSB = 2;
  localparam int LANE_MSB     = 1;
  localparam int LANE_LSB     = 0;

  // Word indices inside the packed state.
  localparam int WORD_A = 0;
  localparam int WORD_B = 1;
  localparam int WORD_C = 2;
  localparam int WORD_D = 3;

  localparam int BYTES_PER_STATE = 16;
  localparam int STATE_W         = 8 * BYTES_PER_STATE;

  localparam logic [QR_ADDR_W-1:0] LAST_BYTE = QR_ADDR_W'(BYTES_PER_STATE - 1);

  // Word selected by a peripheral byte address.
  function automatic logic [1:0] addr_word(input logic [QR_ADDR_W-1:0] addr);
    return addr[WORD_SEL_MSB:WORD_SEL_LSB];
  endfunction

  // Byte lane selected by a peripheral byte address (0 = LSB).
  function automatic logic [1:0] addr_lane(input logic [QR_ADDR_W-1:0] addr);
    return addr[LANE_MSB:LANE_LSB];
  endfunction

endpackage

// File: rtl/chacha_qr_host_if.sv
// Stream and peripheral-port bundle of the quarter-round host.
// The host uses the master modport; the fabric/peripheral side uses slave.
interface chacha_qr_host_if #(
  parameter int ROUND_W = 8
);
  import chacha_qr_pkg::*;

  // Input state stream
  logic                 in_valid;
  logic                 in_ready;
  logic [STATE_W-1:0]   in_state;
  logic [ROUND_W-1:0]   in_rounds;

  // Result stream and status
  logic                 out_valid;
  logic                 out_ready;
  logic [STATE_W-1:0]   out_state;
  logic                 busy;

  // Byte-wide quarter-round peripheral port
  logic [QR_ADDR_W-1:0] qr_addr;
  logic                 qr_wr_en;
  logic                 qr_step;
  logic [7:0]           qr_wdata;
  logic [7:0]           qr_rdata;

  modport master (
    input  in_valid, in_state, in_rounds, out_ready, qr_rdata,
    output in_ready, out_valid, out_state, busy,
           qr_addr, qr_wr_en, qr_step, qr_wdata
  );

  modport slave (
    output in_valid, in_state, in_rounds, out_ready, qr_rdata,
    input  in_ready, out_valid, out_state, busy,
           qr_addr, qr_wr_en, qr_step, qr_wdata
  );

endinterface

// File: rtl/chacha_qr_host.sv
// Host-side master for the byte-wide ChaCha quarter-round peripheral.
// Loads a 128-bit state byte by byte, pulses the step strobe a programmable
// number of times, reads the 16 bytes back and offers the result on a
// valid/ready stream. All outputs are registered.
module chacha_qr_host
  import chacha_qr_pkg::*;
#(
  parameter int ROUND_W = 8,
  parameter int RD_LAT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  chacha_qr_host_if.master  bus
);

  // Wait counter only needs to reach RD_LAT; keep at least one bit.
  localparam int                WAIT_W    = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT);

  qr_state_e            fsm;
  logic [QR_ADDR_W-1:0] byte_cnt;
  logic [QR_ADDR_W-1:0] next_byte;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [ROUND_W-1:0]   round_cnt;
  logic [STATE_W-1:0]   src_q;

  assign next_byte = byte_cnt + 1'b1;

  // Capture the input state at the accepting handshake.
  // NOTE: payload-only register, deliberately outside the reset: every
  // transaction reloads it before any byte of it is driven out.
  always_ff @(posedge clk) begin
    if (bus.in_valid && bus.in_ready) begin
      src_q <= bus.in_state;
    end
  end

  // Transaction FSM: LOAD 16 bytes, ROUND steps, READ 16 bytes, DONE handshake.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm           <= ST_IDLE;
      byte_cnt      <= '0;
      wait_cnt      <= '0;
      round_cnt     <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_state <= '0;
      bus.busy      <= 1'b0;
      bus.qr_addr   <= '0;
      bus.qr_wr_en  <= 1'b0;
      bus.qr_step   <= 1'b0;
      bus.qr_wdata  <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            fsm          <= ST_LOAD;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            round_cnt    <= bus.in_rounds;
            byte_cnt     <= '0;
            // Byte 0 goes out in the first LOAD cycle.
            bus.qr_addr  <= '0;
            bus.qr_wr_en <= 1'b1;
            bus.qr_wdata <= bus.in_state[7:0];
          end
        end

        ST_LOAD: begin
          if (byte_cnt == LAST_BYTE) begin
            bus.qr_wr_en <= 1'b0;
            if (round_cnt != '0) begin
              fsm         <= ST_ROUND;
              bus.qr_step <= 1'b1;
            end else begin
              fsm         <= ST_READ;
              bus.qr_addr <= '0;
              byte_cnt    <= '0;
              wait_cnt    <= '0;
            end
          end else begin
            byte_cnt     <= next_byte;
            bus.qr_addr  <= next_byte;
            bus.qr_wdata <= src_q[{next_byte, 3'b000} +: 8];
          end
        end

        ST_ROUND: begin
          // Step is already high for this cycle; drop it after the last one.
          round_cnt <= round_cnt - 1'b1;
          if (round_cnt == ROUND_W'(1)) begin
            fsm         <= ST_READ;
            bus.qr_step <= 1'b0;
            bus.qr_addr <= '0;
            byte_cnt    <= '0;
            wait_cnt    <= '0;
          end
        end

        ST_READ: begin
          // Hold each address RD_LAT+1 cycles, sample on the last one.
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            bus.out_state[{byte_cnt, 3'b000} +: 8] <= bus.qr_rdata;
            if (byte_cnt == LAST_BYTE) begin
              fsm           <= ST_DONE;
              bus.out_valid <= 1'b1;
            end else begin
              byte_cnt    <= next_byte;
              bus.qr_addr <= next_byte;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            fsm           <= ST_IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end

        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha_qr_host.sv
// Self-checking bench for chacha_qr_host. Two hosts (RD_LAT=0 and RD_LAT=2)
// share one stimulus stream, each talking to its own behavioural peripheral.
// Expected results are queued at stimulus time and compared on output.

// One ChaCha quarter round on a packed {d,c,b,a} state.
function automatic logic [127:0] qr_apply(input logic [127:0] st);
  logic [31:0] a, b, c, d;
  a = st[31:0];  b = st[63:32];  c = st[95:64];  d = st[127:96];
  a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
  c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
  a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
  c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
  return {d, c, b, a};
endfunction

// Behavioural quarter-round peripheral plus strobe/address bookkeeping.
module chacha_qr_periph_model
  import chacha_qr_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [QR_ADDR_W-1:0] addr,
  input  logic                 wr_en,
  input  logic                 step,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata,
  output int                   step_cnt,
  output int                   wr_cnt,
  output int                   viol
);
  logic [31:0] w [4];
  int viol_q = 0;

  assign rdata = w[addr_word(addr)][{addr_lane(addr), 3'b000} +: 8];
  assign viol  = viol_q;

  // Byte writes take priority over the step.
  always @(posedge clk) begin
    if (wr_en) begin
      w[addr_word(addr)][{addr_lane(addr), 3'b000} +: 8] <= wdata;
    end else if (step) begin
      {w[WORD_D], w[WORD_C], w[WORD_B], w[WORD_A]} <=
        qr_apply({w[WORD_D], w[WORD_C], w[WORD_B], w[WORD_A]});
    end
  end

  // Per-transaction strobe counts, sampled mid-cycle.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= 0;
      wr_cnt   <= 0;
    end else if (start) begin
      step_cnt <= 0;
      wr_cnt   <= 0;
    end else begin
      if (step)  step_cnt <= step_cnt + 1;
      if (wr_en) wr_cnt   <= wr_cnt + 1;
    end
  end

  // Protocol violations: both strobes high, or writes out of address order.
  always @(negedge clk) begin
    if (rst_n && ((wr_en && step) || (wr_en && (addr != wr_cnt[3:0])))) begin
      viol_q <= viol_q + 1;
    end
  end
endmodule

module tb_chacha_qr_host;
  import chacha_qr_pkg::*;

  localparam int ROUND_W = 8;
  localparam int LAT0    = 0;
  localparam int LAT2    = 2;

  logic               clk       = 1'b0;
  logic               rst_n     = 1'b0;
  logic               in_valid  = 1'b0;
  logic [127:0]       in_state  = '0;
  logic [ROUND_W-1:0] in_rounds = '0;
  logic               out_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q0 [$];
  logic [127:0] exp_q2 [$];
  int step0, step2, wr0, wr2, viol0, viol2;

  always #5 clk = ~clk;

  chacha_qr_host_if #(.ROUND_W(ROUND_W)) bus0 ();
  chacha_qr_host_if #(.ROUND_W(ROUND_W)) bus2 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_state  = in_state;
  assign bus0.in_rounds = in_rounds;
  assign bus0.out_ready = out_ready;
  assign bus2.in_valid  = in_valid;
  assign bus2.in_state  = in_state;
  assign bus2.in_rounds = in_rounds;
  assign bus2.out_ready = out_ready;

  chacha_qr_host #(.ROUND_W(ROUND_W), .RD_LAT(LAT0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));
  chacha_qr_host #(.ROUND_W(ROUND_W), .RD_LAT(LAT2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  chacha_qr_periph_model pm0 (
    .clk(clk), .rst_n(rst_n), .start(bus0.in_valid && bus0.in_ready),
    .addr(bus0.qr_addr), .wr_en(bus0.qr_wr_en), .step(bus0.qr_step),
    .wdata(bus0.qr_wdata), .rdata(bus0.qr_rdata),
    .step_cnt(step0), .wr_cnt(wr0), .viol(viol0));
  chacha_qr_periph_model pm2 (
    .clk(clk), .rst_n(rst_n), .start(bus2.in_valid && bus2.in_ready),
    .addr(bus2.qr_addr), .wr_en(bus2.qr_wr_en), .step(bus2.qr_step),
    .wdata(bus2.qr_wdata), .rdata(bus2.qr_rdata),
    .step_cnt(step2), .wr_cnt(wr2), .viol(viol2));

  function automatic logic [127:0] pack(input logic [31:0] a, b, c, d);
    logic [127:0] st;
    st[32*WORD_A +: 32] = a;
    st[32*WORD_B +: 32] = b;
    st[32*WORD_C +: 32] = c;
    st[32*WORD_D +: 32] = d;
    return st;
  endfunction

  function automatic logic [127:0] qr_n(input logic [127:0] st, input int n);
    logic [127:0] s = st;
    for (int i = 0; i < n; i++) s = qr_apply(s);
    return s;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {in_ready, out_valid, busy, qr_addr, qr_wr_en, qr_step, qr_wdata}
  function automatic logic [16:0] ctrl0();
    return {bus0.in_ready, bus0.out_valid, bus0.busy, bus0.qr_addr,
            bus0.qr_wr_en, bus0.qr_step, bus0.qr_wdata};
  endfunction
  function automatic logic [16:0] ctrl2();
    return {bus2.in_ready, bus2.out_valid, bus2.busy, bus2.qr_addr,
            bus2.qr_wr_en, bus2.qr_step, bus2.qr_wdata};
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!(bus0.in_ready && bus2.in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait", n < 200, 1'b1);
  endtask

  // Queue the expectation and complete the input handshake (edge 0).
  task automatic start_txn(input logic [127:0] st, input int r, input logic [127:0] exp);
    wait_idle();
    exp_q0.push_back(exp);
    exp_q2.push_back(exp);
    in_state  = st;
    in_rounds = ROUND_W'(r);
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_state  = ~st;
    in_rounds = ~ROUND_W'(r);
  endtask

  // Measure latency, optionally back-pressure, then compare against the queue.
  task automatic finish_txn(input string tag, input int r, input int hold);
    int lat0 = -1;
    int lat2 = -1;
    logic [127:0] snap0, snap2;
    logic stable = 1'b1;
    for (int n = 1; n <= 400 && (lat0 < 0 || lat2 < 0); n++) begin
      @(posedge clk); #1;
      if (lat0 < 0 && bus0.out_valid) lat0 = n;
      if (lat2 < 0 && bus2.out_valid) lat2 = n;
    end
    check({tag, "/lat0"}, lat0, 32 + r + 16 * LAT0);
    check({tag, "/lat2"}, lat2, 32 + r + 16 * LAT2);
    check({tag, "/steps0"}, step0, r);
    check({tag, "/steps2"}, step2, r);
    check({tag, "/writes0"}, wr0, 16);
    check({tag, "/writes2"}, wr2, 16);
    if (hold > 0) begin
      snap0 = bus0.out_state;
      snap2 = bus2.out_state;
      for (int i = 0; i < hold; i++) begin
        in_valid = (i % 3 == 0);
        in_state = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        if (!bus0.out_valid || bus0.out_state !== snap0 || bus0.in_ready || !bus0.busy) stable = 1'b0;
        if (!bus2.out_valid || bus2.out_state !== snap2 || bus2.in_ready || !bus2.busy) stable = 1'b0;
      end
      in_valid = 1'b0;
      check({tag, "/hold_stable"}, stable, 1'b1);
    end
    if (exp_q0.size() == 0 || exp_q2.size() == 0) begin
      check({tag, "/sb_nonempty"}, 1'b0, 1'b1);
    end else begin
      check({tag, "/data0"}, bus0.out_state, exp_q0.pop_front());
      check({tag, "/data2"}, bus2.out_state, exp_q2.pop_front());
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/release0"}, {bus0.out_valid, bus0.busy, bus0.in_ready}, 3'b001);
    check({tag, "/release2"}, {bus2.out_valid, bus2.busy, bus2.in_ready}, 3'b001);
    @(posedge clk); #1;
    check({tag, "/stay_idle"}, {bus0.busy, bus2.busy}, 2'b00);
  endtask

  logic [127:0] rfc_in, rfc_out, loop_in, rnd;

  initial begin
    rfc_in  = pack(32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567);
    rfc_out = pack(32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb);
    for (int k = 0; k < 16; k++) loop_in[8*k +: 8] = 8'(k);

    // Reset values while rst_n is held low
    #1;
    check("reset_ctrl0", ctrl0(), 17'h0);
    check("reset_ctrl2", ctrl2(), 17'h0);
    check("reset_out0", bus0.out_state, 128'h0);
    check("reset_out2", bus2.out_state, 128'h0);
    #11 rst_n = 1'b1;

    // RFC 7539 2.1.1 single quarter round
    start_txn(rfc_in, 1, rfc_out);
    finish_txn("rfc", 1, 0);

    // Loopback: no steps, byte k = k
    start_txn(loop_in, 0, loop_in);
    finish_txn("loopback", 0, 0);

    // Three steps with 20 cycles of back-pressure and ignored in_valid pulses
    start_txn(rfc_in, 3, qr_n(rfc_in, 3));
    finish_txn("multi3", 3, 20);

    // Maximum round count, random state
    rnd = {$urandom, $urandom, $urandom, $urandom};
    start_txn(rnd, 255, qr_n(rnd, 255));
    finish_txn("max255", 255, 0);

    // Asynchronous reset in the middle of a long ROUND phase
    begin
      int n = 0;
      start_txn(rfc_in, 200, qr_n(rfc_in, 200));
      while (step0 < 50 && n < 300) begin
        @(negedge clk); #1;
        n++;
      end
      check("midrst_steps", step0, 50);
      rst_n = 1'b0;
      #1;
      check("midrst_ctrl0", ctrl0(), 17'h0);
      check("midrst_ctrl2", ctrl2(), 17'h0);
      check("midrst_out0", bus0.out_state, 128'h0);
      check("midrst_out2", bus2.out_state, 128'h0);
      exp_q0.delete();
      exp_q2.delete();
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
    end

    // Fresh transaction after the reset
    start_txn(rfc_in, 1, rfc_out);
    finish_txn("post_rst", 1, 0);

    check("protocol0", viol0, 0);
    check("protocol2", viol2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if something wedges despite the bounded waits
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
